bit_balance_frame_monitor: RTL

Downstream consumer of the combinational ones/zeros counter. Accepts one per-word ones/zeros count pair per handshake and accumulates over a frame of FRAME_WORDS words. At frame end it presents frame totals, final running disparity, peak absolute disparity and error flags on a valid/ready result port. The block is used for line-code balance checking after the popcount stage.

---
 rtl/bit_balance_frame_monitor_pkg.sv | 26 ++
 rtl/bit_balance_frame_monitor_if.sv | 37 +++
 rtl/bit_balance_frame_monitor.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/bit_balance_frame_monitor_pkg.sv
// Shared types and width helpers for the bit-balance frame monitor.
// Pulled in by the bus interface and by the monitor itself.
package bit_balance_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      REPORT = 2'd2
   } bb_state_t;

   function automatic int cw_f(input int width);
      return $clog2(width) + 2;
   endfunction

   function automatic int tw_f(input int width, input int frame_words);
      return $clog2(width * frame_words + 1);
   endfunction

   // Returns a 32-bit magnitude; callers narrow it to TW bits.
   function automatic logic [31:0] abs_disp(input logic signed [32:0] d);
      logic signed [32:0] a;
      a = (d < 0) ? -d : d;
      return a[31:0];
   endfunction

endpackage

// File: rtl/bit_balance_frame_monitor_if.sv
// Count-pair input handshake plus frame-result output handshake.
// The monitor uses the slave modport; the upstream/parent side uses master.
interface bit_balance_frame_monitor_if
   import bit_balance_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int FRAME_WORDS = 16
);
   localparam int CW = cw_f(WIDTH);
   localparam int TW = tw_f(WIDTH, FRAME_WORDS);

   logic                 in_valid;
   logic                 in_ready;
   logic [CW-1:0]        ones_count;
   logic [CW-1:0]        zeros_count;
   logic                 out_valid;
   logic                 out_ready;
   logic [TW-1:0]        total_ones;
   logic [TW-1:0]        total_zeros;
   logic signed [TW:0]   disparity;
   logic [TW-1:0]        peak_disparity;
   logic                 imbalance;
   logic                 malformed;

   modport master (
      output in_valid, ones_count, zeros_count, out_ready,
      input  in_ready, out_valid, total_ones, total_zeros, disparity,
             peak_disparity, imbalance, malformed
   );

   modport slave (
      input  in_valid, ones_count, zeros_count, out_ready,
      output in_ready, out_valid, total_ones, total_zeros, disparity,
             peak_disparity, imbalance, malformed
   );

endinterface

// File: rtl/bit_balance_frame_monitor.sv
// Accumulates per-word ones/zeros counts over a frame and reports totals,
// final running disparity, peak |disparity| and error flags per frame.
module bit_balance_frame_monitor
   import bit_balance_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int FRAME_WORDS = 16,
   parameter int THRESH      = 8
)(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        clear,
   bit_balance_frame_monitor_if.slave  bus
);
   localparam int CW  = cw_f(WIDTH);
   localparam int TW  = tw_f(WIDTH, FRAME_WORDS);
   localparam int WCW = $clog2(FRAME_WORDS + 1);

   bb_state_t          state_q, state_d;
   logic [WCW-1:0]     word_cnt_q, word_cnt_d;
   logic [TW-1:0]      ones_sum_q, ones_sum_d;
   logic [TW-1:0]      zeros_sum_q, zeros_sum_d;
   logic signed [TW:0] disp_q, disp_d;
   logic [TW-1:0]      peak_q, peak_d;
   logic               mal_q, mal_d;

   logic [TW-1:0]      res_ones_q, res_ones_d;
   logic [TW-1:0]      res_zeros_q, res_zeros_d;
   logic signed [TW:0] res_disp_q, res_disp_d;
   logic [TW-1:0]      res_peak_q, res_peak_d;
   logic               res_imb_q, res_imb_d;
   logic               res_mal_q, res_mal_d;

   logic               accept, start, last, w_bad;
   logic [TW-1:0]      ones_w, zeros_w;
   logic signed [TW:0] w_disp;
   logic [TW-1:0]      b_ones, b_zeros, b_peak, n_ones, n_zeros, n_peak, n_abs;
   logic signed [TW:0] b_disp, n_disp;
   logic               b_mal, n_mal;
   logic [31:0]        n_abs32;

   assign bus.in_ready       = (state_q != REPORT) || bus.out_ready;
   assign bus.out_valid      = (state_q == REPORT);
   assign bus.total_ones     = res_ones_q;
   assign bus.total_zeros    = res_zeros_q;
   assign bus.disparity      = res_disp_q;
   assign bus.peak_disparity = res_peak_q;
   assign bus.imbalance      = res_imb_q;
   assign bus.malformed      = res_mal_q;

   // A word accepted outside ACCUM opens a new frame, so it adds onto zero.
   always_comb begin
      accept  = bus.in_valid && bus.in_ready;
      start   = (state_q != ACCUM);
      ones_w  = TW'(bus.ones_count);
      zeros_w = TW'(bus.zeros_count);
      w_disp  = $signed({1'b0, ones_w}) - $signed({1'b0, zeros_w});
      w_bad   = ({1'b0, bus.ones_count} + {1'b0, bus.zeros_count}) != (CW+1)'(WIDTH);

      b_ones  = start ? '0 : ones_sum_q;
      b_zeros = start ? '0 : zeros_sum_q;
      b_disp  = start ? '0 : disp_q;
      b_peak  = start ? '0 : peak_q;
      b_mal   = start ? 1'b0 : mal_q;

      n_ones  = b_ones + ones_w;
      n_zeros = b_zeros + zeros_w;
      n_disp  = b_disp + w_disp;
      n_abs32 = abs_disp(33'(n_disp));
      n_abs   = TW'(n_abs32);
      n_peak  = (n_abs > b_peak) ? n_abs : b_peak;
      n_mal   = b_mal | w_bad;
      last    = start ? (FRAME_WORDS == 1) : (word_cnt_q == WCW'(FRAME_WORDS - 1));
   end

   always_comb begin
      state_d     = state_q;
      word_cnt_d  = word_cnt_q;
      ones_sum_d  = ones_sum_q;
      zeros_sum_d = zeros_sum_q;
      disp_d      = disp_q;
      peak_d      = peak_q;
      mal_d       = mal_q;
      res_ones_d  = res_ones_q;
      res_zeros_d = res_zeros_q;
      res_disp_d  = res_disp_q;
      res_peak_d  = res_peak_q;
      res_imb_d   = res_imb_q;
      res_mal_d   = res_mal_q;

      if (clear) begin
         state_d     = IDLE;
         word_cnt_d  = '0;
         ones_sum_d  = '0;
         zeros_sum_d = '0;
         disp_d      = '0;
         peak_d      = '0;
         mal_d       = 1'b0;
      end else if (accept) begin
         ones_sum_d  = n_ones;
         zeros_sum_d = n_zeros;
         disp_d      = n_disp;
         peak_d      = n_peak;
         mal_d       = n_mal;
         word_cnt_d  = start ? WCW'(1) : word_cnt_q + WCW'(1);
         if (last) begin
            state_d     = REPORT;
            res_ones_d  = n_ones;
            res_zeros_d = n_zeros;
            res_disp_d  = n_disp;
            res_peak_d  = n_peak;
            res_imb_d   = (n_abs32 > 32'(THRESH));
            res_mal_d   = n_mal;
         end else begin
            state_d = ACCUM;
         end
      end else if (state_q == REPORT && bus.out_ready) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         word_cnt_q  <= '0;
         ones_sum_q  <= '0;
         zeros_sum_q <= '0;
         disp_q      <= '0;
         peak_q      <= '0;
         mal_q       <= 1'b0;
         res_ones_q  <= '0;
         res_zeros_q <= '0;
         res_disp_q  <= '0;
         res_peak_q  <= '0;
         res_imb_q   <= 1'b0;
         res_mal_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         word_cnt_q  <= word_cnt_d;
         ones_sum_q  <= ones_sum_d;
         zeros_sum_q <= zeros_sum_d;
         disp_q      <= disp_d;
         peak_q      <= peak_d;
         mal_q       <= mal_d;
         res_ones_q  <= res_ones_d;
         res_zeros_q <= res_zeros_d;
         res_disp_q  <= res_disp_d;
         res_peak_q  <= res_peak_d;
         res_imb_q   <= res_imb_d;
         res_mal_q   <= res_mal_d;
      end
   end

endmodule
